// File: rtl/occupancy_pkg.sv
// ----------------------------------------------------------------------------
// occupancy_pkg
// Shared definitions for the doorway occupancy path: the entry/exit FSM state
// encoding and the default debounce / timeout lengths. The occupancy counter
// and its bench pick up the same defaults from here.
// ----------------------------------------------------------------------------
package occupancy_pkg;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 4;
    localparam int DEFAULT_TIMEOUT_CYCLES  = 64;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_A_FIRST    = 3'd1;
    localparam logic [2:0] ST_AB_BOTH    = 3'd2;
    localparam logic [2:0] ST_A_CLEAR    = 3'd3;
    localparam logic [2:0] ST_B_FIRST    = 3'd4;
    localparam logic [2:0] ST_BA_BOTH    = 3'd5;
    localparam logic [2:0] ST_B_CLEAR    = 3'd6;
    localparam logic [2:0] ST_WAIT_CLEAR = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE       = ST_IDLE,
        S_A_FIRST    = ST_A_FIRST,
        S_AB_BOTH    = ST_AB_BOTH,
        S_A_CLEAR    = ST_A_CLEAR,
        S_B_FIRST    = ST_B_FIRST,
        S_BA_BOTH    = ST_BA_BOTH,
        S_B_CLEAR    = ST_B_CLEAR,
        S_WAIT_CLEAR = ST_WAIT_CLEAR
    } crossing_state_t;

endpackage

// File: rtl/input_debouncer.sv
// ----------------------------------------------------------------------------
// input_debouncer
// Two-flop synchroniser followed by a level debouncer for one raw sensor.
// The filtered level follows the synchronised input only after it has
// disagreed with the current level for DEBOUNCE_CYCLES consecutive cycles;
// any agreeing sample restarts the count.
//
// Ports:
//   clk    in  system clock, rising edge
//   reset  in  asynchronous active-high reset
//   raw    in  raw sensor, asynchronous to clk (1 = beam blocked)
//   level  out debounced, clk-synchronous sensor level
// ----------------------------------------------------------------------------
module input_debouncer
    import occupancy_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_meta;
    logic          sync_out;
    logic [CW-1:0] stable_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_meta <= 1'b0;
            sync_out  <= 1'b0;
        end else begin
            sync_meta <= raw;
            sync_out  <= sync_meta;
        end
    end

    // The count never exceeds CNT_LAST: the level flips on the sample that
    // would complete the run, which also restarts the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level      <= 1'b0;
            stable_cnt <= '0;
        end else if (sync_out == level) begin
            stable_cnt <= '0;
        end else if (stable_cnt >= CNT_LAST) begin
            level      <= sync_out;
            stable_cnt <= '0;
        end else begin
            stable_cnt <= stable_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/entry_exit_detector.sv
// ----------------------------------------------------------------------------
// entry_exit_detector
// Turns two doorway beam sensors (A outside, B inside) into single-cycle
// increment / decrement pulses for the occupancy counter. Only complete
// A->B (entry) or B->A (exit) crossings produce a pulse; one-step reversals
// back up silently, anything else or a stall aborts and waits for 00.
//
// Ports:
//   clk        in  system clock, rising edge
//   reset      in  asynchronous active-high reset
//   sensor_a   in  raw outside sensor (1 = blocked), asynchronous
//   sensor_b   in  raw inside sensor (1 = blocked), asynchronous
//   increment  out one-cycle pulse per completed entry
//   decrement  out one-cycle pulse per completed exit
//   abort      out one-cycle pulse when a crossing is abandoned
//   busy       out high while the FSM is out of IDLE
//
// state       | meaning
// ------------+--------------------------------------------------------
// IDLE        | doorway clear, no crossing in progress
// A_FIRST     | only A blocked, entry started
// AB_BOTH     | both blocked during an entry
// A_CLEAR     | A released, only B blocked, entry about to complete
// B_FIRST     | only B blocked, exit started
// BA_BOTH     | both blocked during an exit
// B_CLEAR     | B released, only A blocked, exit about to complete
// WAIT_CLEAR  | crossing abandoned, waiting for both beams to clear
// ----------------------------------------------------------------------------
module entry_exit_detector
    import occupancy_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int TIMEOUT_CYCLES  = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic sensor_a,
    input  logic sensor_b,
    output logic increment,
    output logic decrement,
    output logic abort,
    output logic busy
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic            level_a;
    logic            level_b;
    logic [1:0]      ab;
    crossing_state_t state;
    crossing_state_t state_next;
    logic [TW-1:0]   tcnt;
    logic            timing_state;
    logic            timeout_hit;
    logic            inc_next;
    logic            dec_next;
    logic            abort_next;

    input_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_deb_a (
        .clk   (clk),
        .reset (reset),
        .raw   (sensor_a),
        .level (level_a)
    );

    input_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_deb_b (
        .clk   (clk),
        .reset (reset),
        .raw   (sensor_b),
        .level (level_b)
    );

    assign ab = {level_a, level_b};

    assign timing_state = (state != S_IDLE) && (state != S_WAIT_CLEAR);

    // Firing one count early makes the abort transition land exactly
    // TIMEOUT_CYCLES edges after the state was entered.
    assign timeout_hit = timing_state && (tcnt >= TO_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tcnt <= '0;
        end else if (state_next != state) begin
            tcnt <= '0;
        end else if (timing_state && (tcnt != TO_MAX)) begin
            tcnt <= tcnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A timeout only applies while the pattern holds; a pattern change in
    // the same cycle is taken as the real event.
    always_comb begin
        state_next = state;
        inc_next   = 1'b0;
        dec_next   = 1'b0;
        abort_next = 1'b0;
        case (state)
            S_IDLE: begin
                case (ab)
                    2'b10: state_next = S_A_FIRST;
                    2'b01: state_next = S_B_FIRST;
                    2'b11: begin
                        state_next = S_WAIT_CLEAR;
                        abort_next = 1'b1;
                    end
                    default: state_next = S_IDLE;
                endcase
            end
            S_A_FIRST: begin
                case (ab)
                    2'b10: begin
                        if (timeout_hit) begin
                            state_next = S_WAIT_CLEAR;
                            abort_next = 1'b1;
                        end
                    end
                    2'b11: state_next = S_AB_BOTH;
                    2'b00: state_next = S_IDLE;
                    default: begin
                        state_next = S_WAIT_CLEAR;
                        abort_next = 1'b1;
                    end
                endcase
            end
            S_AB_BOTH: begin
                case (ab)
                    2'b11: begin
                        if (timeout_hit) begin
                            state_next = S_WAIT_CLEAR;
                            abort_next = 1'b1;
                        end
                    end
                    2'b01: state_next = S_A_CLEAR;
                    2'b10: state_next = S_A_FIRST;
                    default: begin
                        state_next = S_WAIT_CLEAR;
                        abort_next = 1'b1;
                    end
                endcase
            end
            S_A_CLEAR: begin
                case (ab)
                    2'b01: begin
                        if (timeout_hit) begin
                            state_next = S_WAIT_CLEAR;
                            abort_next = 1'b1;
                        end
                    end
                    2'b00: begin
                        state_next = S_IDLE;
                        inc_next   = 1'b1;
                    end
                    2'b11: state_next = S_AB_BOTH;
                    default: begin
                        state_next = S_WAIT_CLEAR;
                        abort_next = 1'b1;
                    end
                endcase
            end
            S_B_FIRST: begin
                case (ab)
                    2'b01: begin
                        if (timeout_hit) begin
                            state_next = S_WAIT_CLEAR;
                            abort_next = 1'b1;
                        end
                    end
                    2'b11: state_next = S_BA_BOTH;
                    2'b00: state_next = S_IDLE;
                    default: begin
                        state_next = S_WAIT_CLEAR;
                        abort_next = 1'b1;
                    end
                endcase
            end
            S_BA_BOTH: begin
                case (ab)
                    2'b11: begin
                        if (timeout_hit) begin
                            state_next = S_WAIT_CLEAR;
                            abort_next = 1'b1;
                        end
                    end
                    2'b10: state_next = S_B_CLEAR;
                    2'b01: state_next = S_B_FIRST;
                    default: begin
                        state_next = S_WAIT_CLEAR;
                        abort_next = 1'b1;
                    end
                endcase
            end
            S_B_CLEAR: begin
                case (ab)
                    2'b10: begin
                        if (timeout_hit) begin
                            state_next = S_WAIT_CLEAR;
                            abort_next = 1'b1;
                        end
                    end
                    2'b00: begin
                        state_next = S_IDLE;
                        dec_next   = 1'b1;
                    end
                    2'b11: state_next = S_BA_BOTH;
                    default: begin
                        state_next = S_WAIT_CLEAR;
                        abort_next = 1'b1;
                    end
                endcase
            end
            S_WAIT_CLEAR: begin
                if (ab == 2'b00) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            increment <= 1'b0;
            decrement <= 1'b0;
            abort     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            increment <= inc_next;
            decrement <= dec_next;
            abort     <= abort_next;
            busy      <= (state_next != S_IDLE);
        end
    end

endmodule

// File: tb/tb_entry_exit_detector.sv
module tb_entry_exit_detector;

    localparam logic [1:0] K_INC   = 2'd1;
    localparam logic [1:0] K_DEC   = 2'd2;
    localparam logic [1:0] K_ABORT = 2'd3;

    typedef struct {
        logic [1:0] kind;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic sensor_a = 1'b0;
    logic sensor_b = 1'b0;
    logic increment;
    logic decrement;
    logic abort;
    logic busy;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb_q[$];

    entry_exit_detector dut (
        .clk       (clk),
        .reset     (reset),
        .sensor_a  (sensor_a),
        .sensor_b  (sensor_b),
        .increment (increment),
        .decrement (decrement),
        .abort     (abort),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // Monitor: every pulse the DUT presents must match the head of the queue.
    always @(negedge clk) begin
        if (!reset && (increment || decrement || abort)) begin
            logic [1:0] got;
            exp_t       e;
            got = increment ? K_INC : (decrement ? K_DEC : K_ABORT);
            n_cmp++;
            if ((int'(increment) + int'(decrement) + int'(abort)) > 1) begin
                n_bad++;
                $display("FAIL exclusive: inc=%0b dec=%0b abort=%0b at cycle %0d, required one-hot",
                         increment, decrement, abort, cyc);
            end else if (sb_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_pulse: kind %0d at cycle %0d, required no pulse", got, cyc);
            end else begin
                e = sb_q.pop_front();
                if (got != e.kind || cyc != e.cyc) begin
                    n_bad++;
                    $display("FAIL pulse: got kind %0d at cycle %0d, required kind %0d at cycle %0d",
                             got, cyc, e.kind, e.cyc);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_pulse(input logic [1:0] k, input int c);
        exp_t e;
        e.kind = k;
        e.cyc  = c;
        sb_q.push_back(e);
    endtask

    task automatic check_bit(input string name, input logic got, input logic req);
        n_cmp++;
        if (got !== req) begin
            n_bad++;
            $display("FAIL %s: got %0b at cycle %0d, required %0b", name, got, cyc, req);
        end
    endtask

    task automatic run_entry();
        sensor_a = 1'b1; tick(10);
        sensor_b = 1'b1; tick(9);
        check_bit("entry_busy_mid", busy, 1'b1);
        tick(1);
        sensor_a = 1'b0; tick(10);
        sensor_b = 1'b0;
        expect_pulse(K_INC, cyc + 7);
        tick(6);
        check_bit("entry_busy_before", busy, 1'b1);
        tick(1);
        check_bit("entry_busy_after", busy, 1'b0);
        tick(13);
    endtask

    task automatic run_exit();
        sensor_b = 1'b1; tick(10);
        sensor_a = 1'b1; tick(9);
        check_bit("exit_busy_mid", busy, 1'b1);
        tick(1);
        sensor_b = 1'b0; tick(10);
        sensor_a = 1'b0;
        expect_pulse(K_DEC, cyc + 7);
        tick(6);
        check_bit("exit_busy_before", busy, 1'b1);
        tick(1);
        check_bit("exit_busy_after", busy, 1'b0);
        tick(13);
    endtask

    initial begin
        int t;

        // Reset with sensors idle
        #1;
        check_bit("rst_increment", increment, 1'b0);
        check_bit("rst_decrement", decrement, 1'b0);
        check_bit("rst_abort", abort, 1'b0);
        check_bit("rst_busy", busy, 1'b0);
        tick(3);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            check_bit("idle_busy", busy, 1'b0);
        end

        run_entry();
        run_exit();

        // Glitch shorter than the debounce window
        sensor_a = 1'b1; tick(3);
        sensor_a = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick(1);
            check_bit("glitch_busy", busy, 1'b0);
        end

        // A blocks then releases: forward one step, back one step
        sensor_a = 1'b1;
        t = cyc;
        tick(6);
        check_bit("rev_busy_pre", busy, 1'b0);
        tick(1);
        check_bit("rev_busy_rise", busy, 1'b1);
        tick(3);
        sensor_a = 1'b0;
        tick(6);
        check_bit("rev_busy_hold", busy, 1'b1);
        tick(1);
        check_bit("rev_busy_fall", busy, 1'b0);
        tick(10);

        // Stall in A_FIRST: A_FIRST at t+7, abort 64 edges later
        sensor_a = 1'b1;
        t = cyc;
        expect_pulse(K_ABORT, t + 7 + 64);
        tick(99);
        check_bit("to_busy_wait", busy, 1'b1);
        tick(1);
        sensor_a = 1'b0;
        tick(6);
        check_bit("to_busy_hold", busy, 1'b1);
        tick(1);
        check_bit("to_busy_fall", busy, 1'b0);
        tick(10);
        run_entry();

        // Reset in AB_BOTH with both beams still blocked
        sensor_a = 1'b1; tick(10);
        sensor_b = 1'b1; tick(10);
        reset = 1'b1;
        tick(1);
        check_bit("mid_rst_increment", increment, 1'b0);
        check_bit("mid_rst_abort", abort, 1'b0);
        check_bit("mid_rst_busy", busy, 1'b0);
        tick(2);
        reset = 1'b0;
        t = cyc;
        // Both filtered levels rise together: ambiguous from IDLE
        expect_pulse(K_ABORT, t + 7);
        tick(6);
        check_bit("mid_busy_pre", busy, 1'b0);
        tick(2);
        check_bit("mid_busy_wait", busy, 1'b1);
        tick(2);
        sensor_b = 1'b0; tick(10);
        sensor_a = 1'b0;
        tick(6);
        check_bit("mid_busy_hold", busy, 1'b1);
        tick(1);
        check_bit("mid_busy_fall", busy, 1'b0);
        tick(20);

        while (sb_q.size() != 0) begin
            exp_t e;
            e = sb_q.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL missing_pulse: got none, required kind %0d at cycle %0d", e.kind, e.cyc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
